instr_fetch_sequencer: RTL

INSTR_FETCH_SEQUENCER -- requirements
Module: instr_fetch_sequencer

---
 rtl/aap_fetch_pkg.sv | 6 +
 rtl/fetch_perf_counters.sv | 19 +
 rtl/instr_fetch_sequencer.sv | 82 ++++++++
 3 files changed

// File: rtl/aap_fetch_pkg.sv
// aap_fetch_pkg: fetch sequencer state encoding and shared constants
package aap_fetch_pkg;
    typedef enum logic [2:0] {IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, OUT, DRAIN} fetch_state_t;
    localparam int PC_WIDTH_DEFAULT = 24;
    localparam int IS32_BIT = 15;
endpackage

// File: rtl/fetch_perf_counters.sv
// fetch_perf_counters: two saturating counters of accepted 16-bit and 32-bit instructions
module fetch_perf_counters (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc16,
    input  logic        inc32,
    output logic [15:0] count16,
    output logic [15:0] count32
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count16 <= '0;
            count32 <= '0;
        end else begin
            if (inc16 && count16 != 16'hFFFF) count16 <= count16 + 16'd1;
            if (inc32 && count32 != 16'hFFFF) count32 <= count32 + 16'd1;
        end
    end
endmodule

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: fetches 16/32-bit instructions one halfword at a time for the decoder.
// Define FETCH_PERF_COUNTERS_EN to build the accepted-instruction counters; otherwise they read 0.
module instr_fetch_sequencer
    import aap_fetch_pkg::*;
#(
    parameter int                  PC_WIDTH = PC_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic                mem_req,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic [15:0]         mem_rdata,
    input  logic                mem_rvalid,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [31:0]         instr,
    output logic                instr_is32,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic [15:0]         count16,
    output logic [15:0]         count32
);
    fetch_state_t        state;
    logic [PC_WIDTH-1:0] pc;

    assign mem_req     = (state == REQ_LO || state == REQ_HI) && !redirect;
    assign mem_addr    = (state == REQ_HI) ? pc + PC_WIDTH'(1) : pc;
    assign instr_valid = (state == OUT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr      <= '0;
            instr_is32 <= 1'b0;
            instr_pc   <= RESET_PC;
        end else if (redirect) begin
            pc    <= redirect_pc;
            // a response still in flight must be swallowed before refetching
            state <= (!mem_rvalid && (state == WAIT_LO || state == WAIT_HI || state == DRAIN)) ? DRAIN : REQ_LO;
        end else begin
            case (state)
                IDLE:    if (enable) state <= REQ_LO;
                REQ_LO:  state <= WAIT_LO;
                WAIT_LO: if (mem_rvalid) begin
                    instr      <= {16'h0000, mem_rdata};
                    instr_is32 <= mem_rdata[IS32_BIT];
                    instr_pc   <= pc;
                    state      <= mem_rdata[IS32_BIT] ? REQ_HI : OUT;
                end
                REQ_HI:  state <= WAIT_HI;
                WAIT_HI: if (mem_rvalid) begin
                    instr[31:16] <= mem_rdata;
                    state        <= OUT;
                end
                OUT:     if (instr_ready) begin
                    pc    <= pc + (instr_is32 ? PC_WIDTH'(2) : PC_WIDTH'(1));
                    state <= enable ? REQ_LO : IDLE;
                end
                DRAIN:   if (mem_rvalid) state <= REQ_LO;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    fetch_perf_counters u_perf (
        .clock   (clock),
        .reset   (reset),
        .inc16   (instr_valid && instr_ready && !redirect && !instr_is32),
        .inc32   (instr_valid && instr_ready && !redirect && instr_is32),
        .count16 (count16),
        .count32 (count32)
    );
`else
    assign count16 = '0;
    assign count32 = '0;
`endif
endmodule
